multdiv_stall_ctrl: RTL and testbench
=====================================

// Module: multdiv_stall_ctrl
// PURPOSE
// Parametrised stall controller for the multi-cycle HI/LO unit of the single-cycle CPU.
// Decodes MULT/MULTU/DIV/DIVU from the current instruction word.
// Freezes fetch and PC for a per-operation latency, then issues a one-cycle done pulse.
// Supports separate mult/div latencies, optional divide, a kill input, and back-to-back issue.
// Sits beside the PC/IF-register logic and drives their enables and the HI/LO unit start/busy.
// PARAMETERS
// MULT_LAT    32  BUSY cycles for MULT/MULTU; legal 1..2**CNT_W-1
// DIV_LAT     32  BUSY cycles for DIV/DIVU; legal 1..2**CNT_W-1
// CNT_W       6   cycle counter width
// ENABLE_DIV  1   0: DIV/DIVU are not detected; they pass as ordinary instructions
// PORTS
// clk         in   1      clock, all state updates on rising edge
// rst         in   1      synchronous, active-high reset
// instr       in   32     current instruction word
// instr_valid in   1      instr is a real instruction; 0 blocks detection
// kill        in   1      abort the operation in progress (exception/flush)
// en_ctrl     out  3      {en_IF, flush, en_PC}: 3'b101 free, 3'b000 stall
// busy        out  1      HI/LO unit operating; high in every BUSY cycle
// start       out  1      one-cycle pulse in the first BUSY cycle
// done        out  1      one-cycle pulse; HI/LO results valid
// op_kind     out  2      latched op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (= funct[1:0])
// BEHAVIOUR
// Decode: opcode instr[31:26]==6'd0 and funct instr[5:0] in {0x18,0x19,0x1A,0x1B}.
//   0x1A/0x1B match only when ENABLE_DIV=1. No match unless instr_valid=1.
// States: IDLE, BUSY, DONE. state, cnt, op_kind and lat_sel are registers.
// Outputs are Moore, decoded from state; start is (state==BUSY && cnt==0).
// Reset (rst=1 at an edge): state=IDLE, cnt=0, op_kind=2'b00.
//   Outputs then read en_ctrl=3'b101, busy=0, start=0, done=0.
// rst has priority over kill and over decode. A reset mid-BUSY returns to IDLE with no done.
// IDLE: en_ctrl=3'b101, busy=0, done=0.
//   On a decode match: next=BUSY, cnt<=0, op_kind<=funct[1:0], lat_sel<=funct[1].
// BUSY: en_ctrl=3'b000, busy=1; cnt increments by 1 each cycle.
//   When cnt==LAT-1 (LAT = lat_sel ? DIV_LAT : MULT_LAT): next=DONE.
//   Exactly LAT BUSY cycles; cnt never wraps.
//   instr is ignored while in BUSY.
// DONE: en_ctrl=3'b101, busy=0, done=1 for exactly one cycle.
//   Decode is active here: a match goes straight to BUSY (back-to-back, no IDLE gap).
//   Otherwise next=IDLE.
// Latency: match seen in cycle T -> BUSY in T+1..T+LAT -> DONE in T+LAT+1.
// kill=1 in BUSY: next=IDLE, cnt<=0, no done. kill in IDLE/DONE is ignored.
// kill and a final-count cycle together: kill wins, no DONE.
// op_kind holds its value until the next accepted op.
// LAT=1: a single BUSY cycle with start=1, then DONE.
// Illegal encodings with the match bits set but opcode!=0 are not detected.
// TESTING
// 1. rst=1 for 2 cycles -> en_ctrl=3'b101, busy=0, start=0, done=0.
// 2. MULT 0x01090018, valid=1 at T -> start@T+1; en_ctrl=000 T+1..T+32; done@T+33; op_kind=00.
// 3. MULT_LAT=4, DIV_LAT=8: DIVU 0x0109001B -> 8 stall cycles, op_kind=11.
//    Then MULTU 0x01090019 -> 4 stall cycles, op_kind=01.
// 4. MULT held for the whole DONE cycle -> BUSY again at the next edge.
//    Second start pulse is exactly LAT+1 cycles after the first; no IDLE cycle between.
// 5. kill=1 at cnt=5 -> IDLE next cycle, en_ctrl=101, done never asserted.
//    rst at cnt=10 behaves the same way.
// 6. ENABLE_DIV=0: DIV 0x0109001A -> en_ctrl stays 101.
//    Also: MULT with valid=0, and opcode 0x04 with funct 0x18 -> no stall.

Source files
------------

// File: rtl/multdiv_stall_ctrl_if.sv
// Handshake bundle between the CPU fetch/PC logic and the
// HI/LO stall controller.
interface multdiv_stall_ctrl_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        kill;
    logic [2:0]  en_ctrl;
    logic        busy;
    logic        start;
    logic        done;
    logic [1:0]  op_kind;

    modport master (
        output instr, instr_valid, kill,
        input  en_ctrl, busy, start, done, op_kind
    );

    modport slave (
        input  instr, instr_valid, kill,
        output en_ctrl, busy, start, done, op_kind
    );
endinterface

// File: rtl/multdiv_stall_ctrl.sv
// Stall controller for the multi-cycle HI/LO unit: freezes fetch
// and PC for MULT/DIV latency, then pulses done for one cycle.
module multdiv_stall_ctrl #(
    parameter int MULT_LAT   = 32,
    parameter int DIV_LAT    = 32,
    parameter int CNT_W      = 6,
    parameter bit ENABLE_DIV = 1'b1
) (
    input  logic clk,
    input  logic rst,
    multdiv_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             lat_sel_q, lat_sel_d;
    logic [2:0]       en_q;
    logic             busy_q, start_q, done_q;

    logic [5:0] funct;
    logic       is_mul, is_div, match, last;
    logic       unused_bits;

    assign funct  = bus.instr[5:0];
    assign is_mul = (funct == 6'h18) || (funct == 6'h19);
    assign is_div = ENABLE_DIV && ((funct == 6'h1A) || (funct == 6'h1B));
    assign match  = bus.instr_valid && (bus.instr[31:26] == 6'd0)
                    && (is_mul || is_div);
    assign last   = cnt_q == (lat_sel_q ? DIV_LAST : MULT_LAST);

    // Register-field bits are irrelevant to the stall decision.
    assign unused_bits = ^bus.instr[25:6];

    // Next-state: accept ops from IDLE or DONE, count out BUSY, kill aborts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        lat_sel_d = lat_sel_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (match) begin
                    state_d   = BUSY;
                    cnt_d     = '0;
                    op_d      = funct[1:0];
                    lat_sel_d = funct[1];
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (bus.kill) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state plus outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= 2'b00;
            lat_sel_q <= 1'b0;
            en_q      <= 3'b101;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            lat_sel_q <= lat_sel_d;
            en_q      <= (state_d == BUSY) ? 3'b000 : 3'b101;
            busy_q    <= (state_d == BUSY);
            start_q   <= (state_d == BUSY) && (cnt_d == '0);
            done_q    <= (state_d == DONE);
        end
    end

    assign bus.en_ctrl = en_q;
    assign bus.busy    = busy_q;
    assign bus.start   = start_q;
    assign bus.done    = done_q;
    assign bus.op_kind = op_q;

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Scoreboard bench for multdiv_stall_ctrl across four parameter
// sets: default, short lat, no divide, and LAT=1.
module tb_multdiv_stall_ctrl;

    localparam logic [31:0] MULT  = 32'h0109_0018;
    localparam logic [31:0] MULTU = 32'h0109_0019;
    localparam logic [31:0] DIV   = 32'h0109_001A;
    localparam logic [31:0] DIVU  = 32'h0109_001B;
    localparam logic [31:0] BADOP = 32'h1000_0018;

    typedef struct {
        int dut;
        int op;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic [3:0]  vld = '0;
    logic [3:0]  kil = '0;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    int   bc[4];

    always #5 clk = ~clk;

    multdiv_stall_ctrl_if b0 ();
    multdiv_stall_ctrl_if b1 ();
    multdiv_stall_ctrl_if b2 ();
    multdiv_stall_ctrl_if b3 ();

    assign b0.instr = instr;
    assign b1.instr = instr;
    assign b2.instr = instr;
    assign b3.instr = instr;
    assign b0.instr_valid = vld[0];
    assign b1.instr_valid = vld[1];
    assign b2.instr_valid = vld[2];
    assign b3.instr_valid = vld[3];
    assign b0.kill = kil[0];
    assign b1.kill = kil[1];
    assign b2.kill = kil[2];
    assign b3.kill = kil[3];

    multdiv_stall_ctrl u0 (.clk(clk), .rst(rst), .bus(b0));
    multdiv_stall_ctrl #(.MULT_LAT(4), .DIV_LAT(8))
        u1 (.clk(clk), .rst(rst), .bus(b1));
    multdiv_stall_ctrl #(.MULT_LAT(3), .DIV_LAT(3), .ENABLE_DIV(1'b0))
        u2 (.clk(clk), .rst(rst), .bus(b2));
    multdiv_stall_ctrl #(.MULT_LAT(1), .DIV_LAT(2))
        u3 (.clk(clk), .rst(rst), .bus(b3));

    logic       st_w[4], bz_w[4], dn_w[4];
    logic [1:0] ok_w[4];
    logic [2:0] en_w[4];

    always_comb begin
        st_w[0] = b0.start;   st_w[1] = b1.start;
        st_w[2] = b2.start;   st_w[3] = b3.start;
        bz_w[0] = b0.busy;    bz_w[1] = b1.busy;
        bz_w[2] = b2.busy;    bz_w[3] = b3.busy;
        dn_w[0] = b0.done;    dn_w[1] = b1.done;
        dn_w[2] = b2.done;    dn_w[3] = b3.done;
        ok_w[0] = b0.op_kind; ok_w[1] = b1.op_kind;
        ok_w[2] = b2.op_kind; ok_w[3] = b3.op_kind;
        en_w[0] = b0.en_ctrl; en_w[1] = b1.en_ctrl;
        en_w[2] = b2.en_ctrl; en_w[3] = b3.en_ctrl;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: measure BUSY length per op and match each done
    // against the oldest expected transaction.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (st_w[k]) begin
                bc[k] = 0;
                chk($sformatf("start_en_u%0d", k), int'(en_w[k]), 0);
            end
            if (bz_w[k]) bc[k]++;
            if (dn_w[k]) begin
                chk($sformatf("done_en_u%0d", k), int'(en_w[k]), 5);
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done u%0d: got done expected none",
                             k);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_dut", k, e.dut);
                    chk($sformatf("op_kind_u%0d", k), int'(ok_w[k]), e.op);
                    chk($sformatf("busy_cycles_u%0d", k), bc[k], e.lat);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int k, input int op, input int lat);
        exp_t e;
        e.dut = k;
        e.op  = op;
        e.lat = lat;
        q.push_back(e);
    endtask

    task automatic issue(input int k, input logic [31:0] w);
        instr  = w;
        vld[k] = 1'b1;
        @(negedge clk);
        vld[k] = 1'b0;
    endtask

    // Called one cycle after issue; exp_n is cycles from issue to done.
    task automatic wait_done(input int k, input int exp_n);
        int n = 1;
        while (!dn_w[k] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!dn_w[k]) begin
            tests++;
            fails++;
            $display("FAIL done_timeout u%0d: got no done expected at %0d",
                     k, exp_n);
        end else begin
            chk($sformatf("done_latency_u%0d", k), n, exp_n);
        end
        @(negedge clk);
    endtask

    task automatic chk_idle(input string nm, input int k);
        chk({nm, "_en"}, int'(en_w[k]), 5);
        chk({nm, "_busy"}, int'(bz_w[k]), 0);
        chk({nm, "_done"}, int'(dn_w[k]), 0);
    endtask

    initial begin
        int n;

        rst = 1'b1;
        tick(2);
        chk_idle("rst_u0", 0);
        chk("rst_start_u0", int'(st_w[0]), 0);
        chk("rst_op_u0", int'(ok_w[0]), 0);
        chk_idle("rst_u1", 1);
        rst = 1'b0;
        tick(1);

        push(0, 0, 32);
        issue(0, MULT);
        chk("mult_start", int'(st_w[0]), 1);
        chk("mult_en", int'(en_w[0]), 0);
        wait_done(0, 33);

        push(1, 3, 8);
        issue(1, DIVU);
        wait_done(1, 9);
        push(1, 1, 4);
        issue(1, MULTU);
        wait_done(1, 5);
        tick(3);
        chk("op_hold_u1", int'(ok_w[1]), 1);

        push(1, 0, 4);
        push(1, 0, 4);
        instr  = MULT;
        vld[1] = 1'b1;
        @(negedge clk);
        chk("b2b_start1", int'(st_w[1]), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!st_w[1] && n < 20);
        vld[1] = 1'b0;
        chk("b2b_gap", n, 5);
        wait_done(1, 5);

        issue(0, MULT);
        tick(5);
        chk("kill_pre_busy", int'(bz_w[0]), 1);
        kil[0] = 1'b1;
        @(negedge clk);
        kil[0] = 1'b0;
        chk_idle("kill_u0", 0);
        tick(40);

        issue(0, MULT);
        tick(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst_mid_u0", 0);
        tick(40);

        issue(1, MULT);
        tick(3);
        kil[1] = 1'b1;
        @(negedge clk);
        kil[1] = 1'b0;
        chk_idle("kill_last_u1", 1);
        tick(6);

        push(1, 0, 4);
        kil[1] = 1'b1;
        issue(1, MULT);
        kil[1] = 1'b0;
        wait_done(1, 5);

        issue(2, DIV);
        chk_idle("nodiv_u2", 2);
        instr = MULT;
        @(negedge clk);
        chk_idle("novalid_u2", 2);
        issue(2, BADOP);
        chk_idle("badop_u2", 2);
        push(2, 0, 3);
        issue(2, MULT);
        wait_done(2, 4);

        push(3, 0, 1);
        issue(3, MULT);
        chk("lat1_start", int'(st_w[3]), 1);
        chk("lat1_busy", int'(bz_w[3]), 1);
        wait_done(3, 2);
        push(3, 2, 2);
        issue(3, DIV);
        wait_done(3, 3);

        tick(2);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
